// File: rtl/store_narrow_buffer_pkg.sv
// store_narrow_buffer_pkg: shared load/store op encodings and byte-enable constants
package store_narrow_buffer_pkg;
  typedef logic [2:0] mem_op_t;
  // Load extender ops
  localparam mem_op_t EXT_LB  = 3'd0;
  localparam mem_op_t EXT_LH  = 3'd1;
  localparam mem_op_t EXT_LW  = 3'd2;
  localparam mem_op_t EXT_LBU = 3'd3;
  localparam mem_op_t EXT_LHU = 3'd4;
  // Store narrower ops
  localparam mem_op_t ST_WORD = 3'd0;
  localparam mem_op_t ST_HALF = 3'd1;
  localparam mem_op_t ST_BYTE = 3'd2;
  localparam logic [3:0] BE_ALL = 4'b1111;
endpackage

// File: rtl/store_lane_pack.sv
// store_lane_pack: replicates store data into byte lanes, builds byte enables and flags misalignment
module store_lane_pack
  import store_narrow_buffer_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_op,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic        o_misalign
);
  // Lane replication, enables and alignment are pure functions of size and low address bits
  always_comb begin
    o_wdata    = i_op == ST_BYTE ? {4{i_data[7:0]}} :
                 i_op == ST_HALF ? {2{i_data[15:0]}} : i_data;
    o_be       = i_op == ST_BYTE ? 4'b0001 << i_addr :
                 i_op == ST_HALF ? (i_addr[1] ? 4'b1100 : 4'b0011) :
                 i_op == ST_WORD ? BE_ALL : 4'b0000;
    o_misalign = i_op == ST_WORD ? i_addr != 2'b00 :
                 i_op == ST_HALF ? i_addr[0] :
                 i_op != ST_BYTE;
  end
endmodule

// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer: narrows MEM-stage stores into byte lanes and queues them toward data memory
module store_narrow_buffer
  import store_narrow_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [31:0]   in_data,
  input  logic [2:0]    in_op,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  output logic          pending,
  output logic          err_align,
  output logic [AW-1:0] err_addr
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-3:0] r_addr_q [DEPTH];
  logic [31:0]   r_data_q [DEPTH];
  logic [3:0]    r_be_q   [DEPTH];
  logic [PW:0]   r_count;
  logic [PW-1:0] r_wptr, r_rptr;
  logic          r_err;
  logic [AW-1:0] r_err_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic          w_misalign, w_full, w_empty, w_accept, w_push, w_pop;

  store_lane_pack u_pack (
    .i_addr     (in_addr[1:0]),
    .i_data     (in_data),
    .i_op       (in_op),
    .o_wdata    (w_wdata),
    .o_be       (w_be),
    .o_misalign (w_misalign)
  );

  // Handshake decode; ready and valid come only from the registered count
  always_comb begin
    w_full   = r_count == (PW+1)'(DEPTH);
    w_empty  = r_count == '0;
    w_accept = in_valid && !w_full;
    w_push   = w_accept && !w_misalign;
    w_pop    = !w_empty && mem_ready;
  end

  // Entry storage holds already-narrowed stores; contents need no reset since count gates them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_q[r_wptr] <= in_addr[AW-1:2];
      r_data_q[r_wptr] <= w_wdata;
      r_be_q[r_wptr]   <= w_be;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy including the full state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // Rejected stores pulse the error flag for one cycle and latch the offending address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_err <= w_accept && w_misalign;
      if (w_accept && w_misalign) r_err_addr <= in_addr;
    end
  end

  // Head entry is presented only while occupied, otherwise outputs read as zero
  always_comb begin
    in_ready  = !w_full;
    mem_valid = !w_empty;
    pending   = !w_empty;
    mem_addr  = w_empty ? '0 : {r_addr_q[r_rptr], 2'b00};
    mem_wdata = w_empty ? '0 : r_data_q[r_rptr];
    mem_be    = w_empty ? '0 : r_be_q[r_rptr];
    err_align = r_err;
    err_addr  = r_err_addr;
  end
endmodule

// File: tb/tb_store_narrow_buffer.sv
// tb_store_narrow_buffer: directed and random stores checked against a queue-based model
module tb_store_narrow_buffer;
  import store_narrow_buffer_pkg::*;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [31:0]   in_data = '0;
  logic [2:0]    in_op = '0;
  logic          in_ready, mem_valid, pending, err_align;
  logic [AW-1:0] mem_addr, err_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;

  store_narrow_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_op     (in_op),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .pending   (pending),
    .err_align (err_align),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t        q[$];
  logic        m_err = 1'b0;
  logic [31:0] m_err_addr = '0;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit aligned(input logic [31:0] a, input logic [2:0] op);
    if (op == ST_WORD) return a % 4 == 0;
    if (op == ST_HALF) return a % 2 == 0;
    return op == ST_BYTE;
  endfunction

  function automatic ent_t narrow(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    ent_t e;
    e.a = a & ~32'd3;
    if (op == ST_BYTE) begin
      e.d  = (d & 32'hFF) * 32'h0101_0101;
      e.be = 4'(1 << (a % 4));
    end else if (op == ST_HALF) begin
      e.d  = (d & 32'hFFFF) * 32'h0001_0001;
      e.be = (a % 4 >= 2) ? 4'd12 : 4'd3;
    end else begin
      e.d  = d;
      e.be = 4'd15;
    end
    return e;
  endfunction

  task automatic check_all();
    ent_t h;
    h = q.size() > 0 ? q[0] : '0;
    check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    check("mem_valid", 64'(mem_valid), 64'(q.size() > 0));
    check("pending", 64'(pending), 64'(q.size() > 0));
    check("mem_addr", 64'(mem_addr), 64'(h.a));
    check("mem_wdata", 64'(mem_wdata), 64'(h.d));
    check("mem_be", 64'(mem_be), 64'(h.be));
    check("err_align", 64'(err_align), 64'(m_err));
    check("err_addr", 64'(err_addr), 64'(m_err_addr));
  endtask

  // Called at a falling edge: drive one cycle of stimulus, predict the next state, check after the edge
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] op, input logic rdy);
    bit acc, bad, pop;
    in_valid = v; in_addr = a; in_data = d; in_op = op; mem_ready = rdy;
    acc = v && q.size() < DEPTH;
    bad = acc && !aligned(a, op);
    pop = q.size() > 0 && rdy;
    if (pop) q.delete(0);
    m_err = bad;
    if (bad) m_err_addr = a;
    if (acc && !bad) q.push_back(narrow(a, d, op));
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 32'h0, ST_WORD, rdy);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check_all();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_err_addr", 64'(err_addr), 64'd0);

    step(1'b1, 32'h0000_1003, 32'h1234_56AB, ST_BYTE, 1'b0);
    check("byte_addr", 64'(mem_addr), 64'h1000);
    check("byte_wdata", 64'(mem_wdata), 64'hABAB_ABAB);
    check("byte_be", 64'(mem_be), 64'b1000);
    idle(1'b1);

    step(1'b1, 32'h0000_2002, 32'hFFFF_8001, ST_HALF, 1'b0);
    check("half_wdata", 64'(mem_wdata), 64'h8001_8001);
    check("half_be", 64'(mem_be), 64'b1100);
    idle(1'b1);

    step(1'b1, 32'h0000_2001, 32'h0000_5555, ST_HALF, 1'b0);
    check("mis_err", 64'(err_align), 64'd1);
    check("mis_err_addr", 64'(err_addr), 64'h2001);
    check("mis_valid", 64'(mem_valid), 64'd0);
    idle(1'b0);
    check("mis_pulse_end", 64'(err_align), 64'd0);
    check("mis_pending", 64'(pending), 64'd0);

    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), ST_WORD, 1'b0);
    check("bp_full", 64'(in_ready), 64'd0);
    step(1'b1, 32'h0000_0201, 32'hDEAD_BEEF, ST_WORD, 1'b0);
    check("bp_held_no_err", 64'(err_align), 64'd0);
    step(1'b1, 32'h0000_0201, 32'hDEAD_BEEF, ST_WORD, 1'b1);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    check("bp_order", 64'(mem_wdata), 64'hA000_0001);
    for (int i = 0; i < 4; i++) idle(1'b1);

    step(1'b1, 32'h300, 32'h1111_1111, ST_WORD, 1'b0);
    step(1'b1, 32'h304, 32'h2222_2222, ST_WORD, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h400 + 32'(i * 2), 32'($urandom), ST_HALF, 1'b1);
    check("pp_count2", 64'(q.size()), 64'd2);
    for (int i = 0; i < 3; i++) idle(1'b1);

    for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(i), 32'h77 + 32'(i), ST_BYTE, 1'b0);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(mem_valid), 64'd0);
    check("rst_mid_ready", 64'(in_ready), 64'd1);
    check("rst_mid_be", 64'(mem_be), 64'd0);
    q.delete();
    m_err = 1'b0;
    m_err_addr = '0;
    @(negedge clk);
    reset_n = 1'b1;
    check_all();
    step(1'b1, 32'h600, 32'hCAFE_F00D, ST_WORD, 1'b0);
    idle(1'b1);
    check("post_rst_alone", 64'(mem_valid), 64'd0);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom, op, 1'($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/store_narrow_buffer.md
Name: store_narrow_buffer

Overview:
- Store-side counterpart of the immediate/load extender: narrows 32-bit register data to byte/half/word lanes with byte enables.
- Sits between the MEM stage and data memory.
- Buffers accepted stores in a small FIFO and drains them to memory over a valid/ready handshake.
- Flags misaligned stores instead of issuing them.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 32, address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  MEM stage presents a store.
- in_ready  out  1  buffer can accept; equals !full.
- in_addr  in  AW  byte address of the store.
- in_data  in  32  register data; low bits hold the value.
- in_op  in  3  store size: ST_WORD, ST_HALF or ST_BYTE.
- mem_valid  out  1  head entry is valid toward memory.
- mem_ready  in  1  memory accepts the head entry this cycle.
- mem_addr  out  AW  word-aligned address: {in_addr[AW-1:2], 2'b00}.
- mem_wdata  out  32  lane-replicated write data.
- mem_be  out  4  byte enables.
- pending  out  1  count != 0; used for load-after-store stall.
- err_align  out  1  one-cycle pulse for a rejected store.
- err_addr  out  AW  address of the last rejected store.

Behaviour:
- Reset (asynchronous, reset_n=0): count=0, read and write pointers=0, in_ready=1, mem_valid=0, pending=0, err_align=0, err_addr=0. mem_addr/mem_wdata/mem_be read as 0 whenever the FIFO is empty. Storage array is not reset.
- Accept: a store is accepted on a rising edge with in_valid && in_ready.
- Alignment check on accept:
  - ST_WORD needs addr[1:0]==0.
  - ST_HALF needs addr[0]==0.
  - ST_BYTE is always aligned.
  - Any other in_op value is an error.
- Rejected store: nothing is enqueued. err_align=1 for exactly the following cycle. err_addr takes in_addr on the same edge and holds until the next error.
- Narrowing:
  - BYTE: wdata={4{data[7:0]}}, be=4'b0001<<addr[1:0].
  - HALF: wdata={2{data[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - WORD: wdata=data, be=4'b1111.
- Narrowing is done before enqueue; the FIFO stores {addr_word, wdata, be}.
- Latency: a store accepted into an empty FIFO at edge N gives mem_valid=1 from edge N onward (one cycle). No combinational path from in_* to mem_*.
- Drain: the head is popped on an edge with mem_valid && mem_ready. mem_* outputs must stay stable while mem_valid && !mem_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full (count==DEPTH): in_ready=0. A same-cycle pop does NOT raise in_ready; there is no combinational ready path.
- Empty (count==0): mem_valid=0. A pop request is ignored.
- Pointer wrap: pointers are modulo DEPTH, with a separate count of width clog2(DEPTH)+1.
- Misaligned store while full: it is not accepted (in_ready=0), so no error is raised. The MEM stage holds it.
- Reset mid-drain: all entries are discarded and the outputs return to reset values immediately.
- FIFO order is preserved. No store merging. No reordering.

Decomposition:
- Shared define file: ST_WORD=3'd0, ST_HALF=3'd1, ST_BYTE=3'd2, alongside the existing EXT_* op constants. BE_ALL=4'b1111.
- One sub-module, store_lane_pack: purely combinational. Inputs addr[1:0], data and op. Outputs wdata, be and misalign.
- FIFO, pointers and error register stay in store_narrow_buffer.

Test Plan:
- Byte store: addr=0x1003, data=0x123456AB, ST_BYTE, accepted on an empty FIFO -> next cycle mem_valid=1, mem_addr=0x1000, mem_wdata=0xABABABAB, mem_be=4'b1000.
- Half store: addr=0x2002, data=0xFFFF8001, ST_HALF -> mem_wdata=0x80018001, mem_be=4'b1100.
- Misaligned half: addr=0x2001, ST_HALF -> err_align high for exactly 1 cycle, err_addr=0x2001, mem_valid stays 0, pending stays 0.
- Backpressure: push 4 words with mem_ready=0 -> in_ready=0 after the 4th. Fifth store is held. Raise mem_ready for 1 cycle -> in_ready=1 the next cycle. Pop order matches push order.
- Simultaneous push/pop at count=2 -> count stays 2. Pointers wrap correctly over 10 consecutive operations.
- Assert reset_n low with 3 entries queued -> mem_valid=0 and in_ready=1 immediately, without waiting for a clock edge. After release, the first new store appears alone.
